// File: rtl/sig_control.sv
// sig_control: highway / country-road traffic light controller.
// Moore FSM with timed yellow and all-red dwells driven by an 8-bit down-counter.
// Optional build macro SIG_CONTROL_XSYNC_EN adds a 2-flop synchronizer on x,
// delaying every x-driven transition by exactly 2 cycles.
// Y2RDELAY and R2GDELAY are expected in 1..255.
//
// state | meaning
// S0    | highway GREEN, country RED; wait for a car on the country road
// S1    | highway YELLOW, country RED; Y2RDELAY cycles
// S2    | all RED; R2GDELAY cycles
// S3    | highway RED, country GREEN; hold while cars keep coming
// S4    | highway RED, country YELLOW; Y2RDELAY cycles

module sig_control #(
    parameter int Y2RDELAY = 3,
    parameter int R2GDELAY = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       x,
    output logic [1:0] highway,
    output logic [1:0] country
);

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    // Counter preload: the state is left on the edge where the counter reads 0,
    // so loading N-1 on entry yields exactly N cycles of residency.
    localparam logic [7:0] Y2R_LOAD = 8'(Y2RDELAY - 1);
    localparam logic [7:0] R2G_LOAD = 8'(R2GDELAY - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       x_fsm;

`ifdef SIG_CONTROL_XSYNC_EN
    logic x_s1_q, x_s2_q;

    // Two-stage synchronizer for the asynchronous car sensor.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            x_s1_q <= 1'b0;
            x_s2_q <= 1'b0;
        end else begin
            x_s1_q <= x;
            x_s2_q <= x_s1_q;
        end
    end

    assign x_fsm = x_s2_q;
`else
    assign x_fsm = x;
`endif

    // Next-state and dwell-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S0: begin
                if (x_fsm) begin
                    state_d = S1;
                    cnt_d   = Y2R_LOAD;
                end
            end
            S1: begin
                if (cnt_q == 8'd0) begin
                    state_d = S2;
                    cnt_d   = R2G_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S2: begin
                if (cnt_q == 8'd0) begin
                    state_d = S3;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S3: begin
                if (!x_fsm) begin
                    state_d = S4;
                    cnt_d   = Y2R_LOAD;
                end
            end
            S4: begin
                if (cnt_q == 8'd0) begin
                    state_d = S0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and counter registers; clear aborts any dwell immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lamp decode from the state register only; illegal codes show all RED.
    always_comb begin
        highway = RED;
        country = RED;
        case (state_q)
            S0: begin highway = GREEN;  country = RED;    end
            S1: begin highway = YELLOW; country = RED;    end
            S2: begin highway = RED;    country = RED;    end
            S3: begin highway = RED;    country = GREEN;  end
            S4: begin highway = RED;    country = YELLOW; end
            default: begin highway = RED; country = RED;  end
        endcase
    end

endmodule

// File: tb/tb_sig_control.sv
// Self-checking bench for sig_control (default build: macro undefined).
module tb_sig_control;

    logic       clock;
    logic       clear;
    logic       x;
    logic [1:0] highway;
    logic [1:0] country;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       clr;
        logic       x;
        logic [1:0] hw;
        logic [1:0] ct;
    } vec_t;

    typedef struct {
        logic [1:0] hw;
        logic [1:0] ct;
        int         idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    sig_control #(.Y2RDELAY(3), .R2GDELAY(2)) dut (
        .clock   (clock),
        .clear   (clear),
        .x       (x),
        .highway (highway),
        .country (country)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void add(logic clr, logic xv, logic [1:0] hw, logic [1:0] ct, int n);
        vec_t v;
        v.clr = clr;
        v.x   = xv;
        v.hw  = hw;
        v.ct  = ct;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [1:0] hw_exp, logic [1:0] ct_exp);
        n_vec++;
        if (highway !== hw_exp || country !== ct_exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got highway=%0d country=%0d, expected highway=%0d country=%0d",
                     name, idx, highway, country, hw_exp, ct_exp);
        end
    endtask

    // Inputs are driven 1 time unit after an edge, outputs sampled 1 unit after the next edge.
    task automatic apply_vecs(string name);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            clear = vecs[i].clr;
            x     = vecs[i].x;
            e.hw  = vecs[i].hw;
            e.ct  = vecs[i].ct;
            e.idx = i;
            sb.push_back(e);
            @(posedge clock);
            #1;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL %s[%0d]: scoreboard empty", name, i);
            end else begin
                e = sb.pop_front();
                check(name, e.idx, e.hw, e.ct);
            end
        end
        vecs.delete();
    endtask

    // Safety invariants checked on every falling edge.
    always @(negedge clock) begin
        if (highway == 2'd3 || country == 2'd3 || (highway != 2'd0 && country != 2'd0)) begin
            n_err++;
            $display("FAIL lamp_invariant: got highway=%0d country=%0d, expected legal codes with one side RED",
                     highway, country);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b1;
        x     = 1'b0;
        #1;
        check("reset_async", 0, 2'd2, 2'd0);

        // Reset held with x toggling, then idle in S0.
        for (int i = 0; i < 5; i++) add(1'b1, i[0], 2'd2, 2'd0, 1);
        add(0, 0, 2'd2, 2'd0, 20);
        // Car arrives: S1 x3, S2 x2, S3; car keeps coming for 10 more cycles.
        add(0, 1, 2'd1, 2'd0, 3);
        add(0, 1, 2'd0, 2'd0, 2);
        add(0, 1, 2'd0, 2'd2, 1);
        add(0, 1, 2'd0, 2'd2, 10);
        // x drops: S4 x3 then back to S0.
        add(0, 0, 2'd0, 2'd1, 3);
        add(0, 0, 2'd2, 2'd0, 2);
        // Single-cycle pulse: full cycle with S3 lasting exactly 1 cycle.
        add(0, 1, 2'd1, 2'd0, 1);
        add(0, 0, 2'd1, 2'd0, 2);
        add(0, 0, 2'd0, 2'd0, 2);
        add(0, 0, 2'd0, 2'd2, 1);
        add(0, 0, 2'd0, 2'd1, 3);
        add(0, 0, 2'd2, 2'd0, 2);
        // x high during S4 is ignored; S4 exits to S0, then x moves to S1.
        add(0, 1, 2'd1, 2'd0, 3);
        add(0, 1, 2'd0, 2'd0, 2);
        add(0, 1, 2'd0, 2'd2, 1);
        add(0, 0, 2'd0, 2'd1, 1);
        add(0, 1, 2'd0, 2'd1, 2);
        add(0, 1, 2'd2, 2'd0, 1);
        add(0, 1, 2'd1, 2'd0, 1);
        add(0, 0, 2'd1, 2'd0, 2);
        add(0, 0, 2'd0, 2'd0, 2);
        add(0, 0, 2'd0, 2'd2, 1);
        add(0, 0, 2'd0, 2'd1, 3);
        add(0, 0, 2'd2, 2'd0, 1);
        // Synchronous-looking clear, then first edge after release applies the S0 rule.
        add(1, 1, 2'd2, 2'd0, 2);
        add(0, 1, 2'd1, 2'd0, 1);
        add(0, 0, 2'd1, 2'd0, 2);
        add(0, 0, 2'd0, 2'd0, 1);
        apply_vecs("seq_main");

        // Now in S2 mid-dwell: clear between edges must act at once.
        #3 clear = 1'b1;
        #1 check("async_clr_s2", 0, 2'd2, 2'd0);
        @(posedge clock);
        #1 check("clr_hold_s2", 0, 2'd2, 2'd0);

        add(0, 1, 2'd1, 2'd0, 1);
        add(0, 0, 2'd1, 2'd0, 2);
        add(0, 0, 2'd0, 2'd0, 2);
        add(0, 0, 2'd0, 2'd2, 1);
        add(0, 0, 2'd0, 2'd1, 2);
        apply_vecs("seq_to_s4");

        // Now in S4 mid-dwell: async clear.
        #3 clear = 1'b1;
        #1 check("async_clr_s4", 0, 2'd2, 2'd0);
        @(posedge clock);
        #1 check("clr_hold_s4", 0, 2'd2, 2'd0);

        add(0, 0, 2'd2, 2'd0, 3);
        apply_vecs("seq_after_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
